// File: rtl/tx_link_sequencer.sv
// Symbol sequencer in front of the TX 8b/10b encoder: alignment burst, idle
// ordered sets, handshaked user data with periodic comma insertion.
module tx_link_sequencer #(
    parameter int ALIGN_LEN    = 16,
    parameter int COMMA_PERIOD = 256
) (
    input  logic       BitCLK_10,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [7:0] Data_In,
    input  logic       DataK_In,
    input  logic       Data_Valid,
    output logic       Data_Ready,
    output logic [7:0] TxParallel_8,
    output logic       TxDataK,
    output logic       Link_Up,
    output logic       K_Err
);
    localparam int AW = (ALIGN_LEN > 1) ? $clog2(ALIGN_LEN) : 1;
    localparam int CW = $clog2(COMMA_PERIOD);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_LEN - 1);
    localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_PERIOD - 1);
    localparam logic [7:0]    K28_5      = 8'hBC;
    localparam logic [7:0]    D16_2      = 8'h50;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ALIGN = 2'd1,
        IDLE  = 2'd2,
        DATA  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   align_cnt_q, align_cnt_d;
    logic [CW-1:0]   comma_cnt_q, comma_cnt_d;
    logic            idle_phase_q, idle_phase_d;
    logic [7:0]      sym_q, sym_d;
    logic            symk_q, symk_d;
    logic            link_up_q, link_up_d;
    logic            k_err_q, k_err_d;

    logic            comma_due_s;
    logic            data_ready_s;
    logic            accept_s;
    logic            beat_legal_s;

    function automatic logic is_legal_k(input logic [7:0] code);
        logic legal;
        case (code)
            8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
            8'hF7, 8'hFB, 8'hFD, 8'hFE: legal = 1'b1;
            default:                    legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Next-state, next-symbol and handshake logic.
    always_comb begin
        state_d      = state_q;
        align_cnt_d  = align_cnt_q;
        comma_cnt_d  = comma_cnt_q;
        idle_phase_d = idle_phase_q;
        sym_d        = K28_5;
        symk_d       = 1'b1;
        link_up_d    = 1'b0;
        k_err_d      = 1'b0;

        comma_due_s  = (state_q == DATA) && (comma_cnt_q == COMMA_LAST);
        data_ready_s = Enable && !comma_due_s &&
                       ((state_q == DATA) || ((state_q == IDLE) && !idle_phase_q));
        accept_s     = data_ready_s && Data_Valid;
        // An illegal control code is replaced by a comma but still consumed.
        beat_legal_s = !DataK_In || is_legal_k(Data_In);

        if (!Enable) begin
            state_d      = OFF;
            align_cnt_d  = '0;
            comma_cnt_d  = '0;
            idle_phase_d = 1'b0;
        end else begin
            link_up_d = (state_q == IDLE) || (state_q == DATA);
            case (state_q)
                OFF: begin
                    state_d     = ALIGN;
                    align_cnt_d = '0;
                end
                ALIGN: begin
                    if (align_cnt_q == ALIGN_LAST) begin
                        state_d      = IDLE;
                        idle_phase_d = 1'b0;
                        align_cnt_d  = '0;
                    end else begin
                        align_cnt_d = align_cnt_q + AW'(1);
                    end
                end
                IDLE: begin
                    if (accept_s) begin
                        sym_d   = beat_legal_s ? Data_In : K28_5;
                        symk_d  = DataK_In;
                        k_err_d = !beat_legal_s;
                        state_d = DATA;
                    end else begin
                        if (idle_phase_q) begin
                            sym_d  = D16_2;
                            symk_d = 1'b0;
                        end else begin
                            sym_d  = K28_5;
                            symk_d = 1'b1;
                        end
                        idle_phase_d = !idle_phase_q;
                    end
                end
                DATA: begin
                    if (comma_due_s) begin
                        state_d = DATA;
                    end else if (accept_s) begin
                        sym_d   = beat_legal_s ? Data_In : K28_5;
                        symk_d  = DataK_In;
                        k_err_d = !beat_legal_s;
                    end else begin
                        // Leaving DATA with a comma; the next idle symbol is D16.2.
                        idle_phase_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = OFF;
                end
            endcase

            if ((sym_d == K28_5) && symk_d) begin
                comma_cnt_d = '0;
            end else if (comma_cnt_q == COMMA_LAST) begin
                comma_cnt_d = comma_cnt_q;
            end else begin
                comma_cnt_d = comma_cnt_q + CW'(1);
            end
        end
    end

    // State, counters and registered symbol outputs.
    always_ff @(posedge BitCLK_10) begin
        if (Reset) begin
            state_q      <= OFF;
            align_cnt_q  <= '0;
            comma_cnt_q  <= '0;
            idle_phase_q <= 1'b0;
            sym_q        <= K28_5;
            symk_q       <= 1'b1;
            link_up_q    <= 1'b0;
            k_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            align_cnt_q  <= align_cnt_d;
            comma_cnt_q  <= comma_cnt_d;
            idle_phase_q <= idle_phase_d;
            sym_q        <= sym_d;
            symk_q       <= symk_d;
            link_up_q    <= link_up_d;
            k_err_q      <= k_err_d;
        end
    end

    assign Data_Ready   = data_ready_s;
    assign TxParallel_8 = sym_q;
    assign TxDataK      = symk_q;
    assign Link_Up      = link_up_q;
    assign K_Err        = k_err_q;

endmodule

// File: tb/tb_tx_link_sequencer.sv
// Self-checking bench for tx_link_sequencer: behavioural link model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_tx_link_sequencer;
    localparam int ALIGN_LEN    = 16;
    localparam int COMMA_PERIOD = 8;
    localparam int M_OFF   = 0;
    localparam int M_ALIGN = 1;
    localparam int M_IDLE  = 2;
    localparam int M_DATA  = 3;

    logic       BitCLK_10 = 1'b0;
    logic       Reset;
    logic       Enable;
    logic [7:0] Data_In;
    logic       DataK_In;
    logic       Data_Valid;
    logic       Data_Ready;
    logic [7:0] TxParallel_8;
    logic       TxDataK;
    logic       Link_Up;
    logic       K_Err;

    int checks   = 0;
    int failures = 0;

    tx_link_sequencer #(
        .ALIGN_LEN   (ALIGN_LEN),
        .COMMA_PERIOD(COMMA_PERIOD)
    ) dut (
        .BitCLK_10   (BitCLK_10),
        .Reset       (Reset),
        .Enable      (Enable),
        .Data_In     (Data_In),
        .DataK_In    (DataK_In),
        .Data_Valid  (Data_Valid),
        .Data_Ready  (Data_Ready),
        .TxParallel_8(TxParallel_8),
        .TxDataK     (TxDataK),
        .Link_Up     (Link_Up),
        .K_Err       (K_Err)
    );

    always #5 BitCLK_10 = ~BitCLK_10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] legal_tbl [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                   8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    function automatic bit legal_k(input logic [7:0] c);
        bit hit = 1'b0;
        for (int i = 0; i < 12; i++) if (legal_tbl[i] == c) hit = 1'b1;
        return hit;
    endfunction

    int         m_mode  = M_OFF;
    int         m_align = 0;   // alignment symbols already sent
    int         m_since = 0;   // symbols since the last K28.5
    int         m_half  = 0;   // 1: next idle symbol is D16.2
    bit         m_known = 1'b0;
    logic [7:0] e_sym;
    logic       e_k, e_lu, e_err;

    initial begin : compare_proc
        bit due, rdy, take;
        forever begin
            @(negedge BitCLK_10);
            due = (m_mode == M_DATA) && (m_since >= COMMA_PERIOD - 1);
            rdy = Enable && !due && (m_mode == M_DATA || (m_mode == M_IDLE && m_half == 0));
            if (m_known) begin
                chk("Data_Ready", Data_Ready, rdy);
                chk("TxParallel_8", TxParallel_8, e_sym);
                chk("TxDataK", TxDataK, e_k);
                chk("Link_Up", Link_Up, e_lu);
                chk("K_Err", K_Err, e_err);
            end
            take  = rdy && Data_Valid;
            e_sym = 8'hBC;
            e_k   = 1'b1;
            e_err = 1'b0;
            e_lu  = Enable && (m_mode == M_IDLE || m_mode == M_DATA);
            if (Reset) begin
                e_lu    = 1'b0;
                m_mode  = M_OFF;
                m_align = 0;
                m_since = 0;
                m_half  = 0;
                m_known = 1'b1;
            end else if (!Enable) begin
                m_mode  = M_OFF;
                m_align = 0;
                m_since = 0;
                m_half  = 0;
            end else begin
                case (m_mode)
                    M_OFF: begin
                        m_mode  = M_ALIGN;
                        m_align = 0;
                    end
                    M_ALIGN: begin
                        m_align++;
                        if (m_align == ALIGN_LEN) begin
                            m_mode = M_IDLE;
                            m_half = 0;
                        end
                    end
                    M_IDLE: begin
                        if (take) begin
                            if (DataK_In && !legal_k(Data_In)) e_err = 1'b1;
                            else begin e_sym = Data_In; e_k = DataK_In; end
                            m_mode = M_DATA;
                        end else begin
                            if (m_half == 1) begin e_sym = 8'h50; e_k = 1'b0; end
                            m_half = 1 - m_half;
                        end
                    end
                    M_DATA: begin
                        if (!due) begin
                            if (take) begin
                                if (DataK_In && !legal_k(Data_In)) e_err = 1'b1;
                                else begin e_sym = Data_In; e_k = DataK_In; end
                            end else begin
                                m_half = 1;
                                m_mode = M_IDLE;
                            end
                        end
                    end
                    default: m_mode = M_OFF;
                endcase
                m_since = (e_sym == 8'hBC && e_k) ? 0 : m_since + 1;
            end
        end
    end

    // ---------------- upstream driver ----------------
    logic [8:0] tx_q [$];
    bit         feed = 1'b0;

    task automatic present();
        if (feed && tx_q.size() > 0) begin
            Data_Valid = 1'b1;
            DataK_In   = tx_q[0][8];
            Data_In    = tx_q[0][7:0];
        end else begin
            Data_Valid = 1'b0;
        end
    endtask

    task automatic tick();
        bit acc;
        @(negedge BitCLK_10);
        acc = Data_Valid && Data_Ready && !Reset;
        @(posedge BitCLK_10);
        #1;
        if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
        present();
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (tx_q.size() > 0 && n < limit) begin
            tick();
            n++;
        end
        chk(name, tx_q.size(), 0);
    endtask

    task automatic send_one(input string name, input logic k, input logic [7:0] d,
                            input logic [7:0] xs, input logic xk, input logic xe);
        tx_q.push_back({k, d});
        feed = 1'b1;
        present();
        drain(name, 20);
        chk({name, "_sym"}, TxParallel_8, xs);
        chk({name, "_k"}, TxDataK, xk);
        chk({name, "_kerr"}, K_Err, xe);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        Reset = 1'b1; Enable = 1'b0; Data_Valid = 1'b0; Data_In = 8'h00; DataK_In = 1'b0;
        repeat (3) tick();
        chk("rst_sym", TxParallel_8, 8'hBC);
        chk("rst_k", TxDataK, 1'b1);
        chk("rst_lu", Link_Up, 1'b0);
        chk("rst_kerr", K_Err, 1'b0);

        // Bring-up: OFF symbol, 16 alignment commas, then idle pairs
        Reset = 1'b0; Enable = 1'b1;
        repeat (17) tick();
        chk("align_lu", Link_Up, 1'b0);
        chk("align_sym", TxParallel_8, 8'hBC);
        tick();
        chk("idle_lu", Link_Up, 1'b1);
        chk("idle_k28", TxParallel_8, 8'hBC);
        chk("idle_k28_k", TxDataK, 1'b1);
        tick();
        chk("idle_d16", TxParallel_8, 8'h50);
        chk("idle_d16_k", TxDataK, 1'b0);

        // Data 00..0F from IDLE; commas land after 05 and 0C
        for (int i = 0; i < 16; i++) tx_q.push_back({1'b0, 8'(i)});
        feed = 1'b1;
        present();
        tick();
        chk("first_beat", TxParallel_8, 8'h00);
        drain("idle_stream", 100);
        chk("last_beat", TxParallel_8, 8'h0F);
        tick();
        chk("tail_k28", TxParallel_8, 8'hBC);
        tick();
        chk("tail_d16", TxParallel_8, 8'h50);
        chk("tail_d16_k", TxDataK, 1'b0);

        // Long continuous stream exercising comma insertion
        for (int i = 1; i < 32; i++) tx_q.push_back({1'b0, 8'(i)});
        present();
        drain("comma_stream", 200);
        repeat (2) tick();

        // Control-code handling
        send_one("k_illegal", 1'b1, 8'h1D, 8'hBC, 1'b1, 1'b1);
        send_one("k_fb", 1'b1, 8'hFB, 8'hFB, 1'b1, 1'b0);
        send_one("k_user_k28", 1'b1, 8'hBC, 8'hBC, 1'b1, 1'b0);
        send_one("d_1d", 1'b0, 8'h1D, 8'h1D, 1'b0, 1'b0);

        // Enable dropped mid-DATA
        for (int i = 0; i < 20; i++) tx_q.push_back({1'b0, 8'(64 + i)});
        present();
        repeat (5) tick();
        Enable = 1'b0;
        #1;
        chk("drop_ready", Data_Ready, 1'b0);
        tick();
        chk("drop_sym", TxParallel_8, 8'hBC);
        chk("drop_k", TxDataK, 1'b1);
        chk("drop_lu", Link_Up, 1'b0);
        feed = 1'b0;
        tx_q.delete();
        present();
        repeat (2) tick();
        Enable = 1'b1;
        repeat (17) tick();
        chk("realign_lu", Link_Up, 1'b0);
        tick();
        chk("realign_up", Link_Up, 1'b1);
        chk("realign_sym", TxParallel_8, 8'hBC);

        // Reset pulse mid-DATA with Enable held
        repeat (2) tick();
        for (int i = 0; i < 16; i++) tx_q.push_back({1'b0, 8'(96 + i)});
        feed = 1'b1;
        present();
        repeat (6) tick();
        Reset = 1'b1;
        tick();
        chk("mid_rst_sym", TxParallel_8, 8'hBC);
        chk("mid_rst_k", TxDataK, 1'b1);
        chk("mid_rst_lu", Link_Up, 1'b0);
        chk("mid_rst_kerr", K_Err, 1'b0);
        Reset = 1'b0;
        repeat (17) tick();
        chk("rst_realign_lu", Link_Up, 1'b0);
        tick();
        chk("rst_realign_up", Link_Up, 1'b1);
        drain("post_reset", 100);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
